return_stack: RTL
=================

Name: return_stack

Overview:
- Hardware LIFO of return addresses; responder side of the push/pop interface driven by the single-cycle datapath for CALL/RET.
- Datapath drives push with pc+1 on CALL; pops on RET and uses top-of-stack as next PC in the same cycle.
- Adds depth tracking, sticky overflow/underflow error flags and a selectable full-stack policy.

Parameters:
- AW, 12, address/entry width in bits (matches PC width).
- DEPTH, 8, number of entries; power of two, >= 2.
- WRAP_ON_FULL, 0. 0 = push when full is dropped. 1 = push when full overwrites the oldest entry (circular).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low.
- push  in  1  push data_in this cycle.
- pop  in  1  pop top entry this cycle.
- data_in  in  AW  value to push (pc+1 from datapath).
- data_out  out  AW  current top of stack, combinational from state.
- count  out  clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.
- err_clear  in  1  clears overflow/underflow on the next edge.

Behaviour:
- Clock and reset: reset is synchronous, active-low; clock is clk. When reset == 0 at a rising edge:
  - count <= 0; top pointer <= 0; overflow <= 0; underflow <= 0.
  - Storage contents are don't-care.
  - Reset overrides push/pop/err_clear in the same cycle.
  - Mid-sequence reset discards all entries.
- data_out:
  - Equals the entry at the top when count > 0; equals 0 when empty.
  - Purely combinational from registered state (no input-to-output path), so the datapath sees the return address in the same cycle pop is asserted.
  - After an edge that applied a pop, data_out shows the new top.
- Operation, by {push, pop} at a rising edge:
  - 00: no change.
  - 10, not full: store data_in at top+1; count += 1.
  - 10, full, WRAP_ON_FULL=0: storage and count unchanged; overflow <= 1.
  - 10, full, WRAP_ON_FULL=1: store data_in, overwriting the oldest entry (pointer wraps mod DEPTH); count stays DEPTH; overflow <= 1.
  - 01, not empty: count -= 1; top moves down one.
  - 01, empty: no change; underflow <= 1.
  - 11, not empty: replace the top entry with data_in; count unchanged (tail-call). No flag.
  - 11, empty: behaves as a push of data_in; count becomes 1. No flag.
- Pointer arithmetic:
  - Top pointer is log2(DEPTH) bits and wraps modulo DEPTH.
  - count saturates at 0 and DEPTH; it never wraps.
- Flags:
  - overflow and underflow are sticky; set on the edge where the faulting request is seen.
  - err_clear == 1 clears both flags on that edge.
  - If a new fault coincides with err_clear, the set wins (flag reads 1 afterwards).
- Status outputs: empty and full are derived from count and never both 1.
- Latency: writes take effect one edge after the request; reads are zero-latency.
- No X may propagate on data_out when empty, including straight out of reset.

Test Plan:
- Reset and empty pop: hold reset=0 for 2 cycles, release, pop once -> data_out=0, count=0, empty=1, underflow=1 after the edge. Then err_clear=1 for one edge -> underflow=0.
- LIFO order: push 0x101, 0x202, 0x303 -> count=3, data_out=0x303. Pop three times -> data_out reads 0x202, 0x101, 0, in that order, each after its edge; empty=1 at the end.
- Full, drop policy (WRAP_ON_FULL=0, DEPTH=8): push 0x001..0x008 -> full=1. Push 0x0FF -> data_out stays 0x008, count=8, overflow=1. Pop 8 times -> 0x007..0x001 then 0 in order.
- Full, wrap policy (WRAP_ON_FULL=1): push 0x001..0x009 -> count=8, overflow=1, data_out=0x009. Pop 8 times -> data_out shows 0x008..0x002 then 0; 0x001 is lost.
- Simultaneous push+pop: with stack {0x010, 0x020}, assert push=pop=1 with data_in=0x0AB -> count=2, data_out=0x0AB. Pop -> data_out=0x010. On an empty stack, push=pop=1 with data_in=0x055 -> count=1, data_out=0x055, no flags.
- Reset mid-operation, plus datapath same-cycle pop:
  - With count=5, assert reset=0 together with push=1 -> count=0, flags=0, data_out=0.
  - With top=0x123, pop=1 -> data_out=0x123 is stable before the edge (RET target).

Source files
------------

// File: rtl/return_stack.sv
// Return-address stack (LIFO) for the single-cycle datapath's CALL/RET.
// CALL pushes pc+1. RET pops and uses data_out_o as the next PC in the same cycle.
// The stack tracks its depth and keeps sticky overflow/underflow flags.
// When full, a push is either dropped or overwrites the oldest entry (WRAP_ON_FULL).
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-low
//   push_i       push data_in_i this cycle
//   pop_i        pop the top entry this cycle
//   data_in_i    value to push
//   err_clear_i  clear overflow/underflow on the next edge
//   data_out_o   current top of stack (0 when empty), combinational from state
//   count_o      number of valid entries, 0..DEPTH
//   empty_o      count_o == 0
//   full_o       count_o == DEPTH
//   overflow_o   sticky: push attempted while full
//   underflow_o  sticky: pop attempted while empty
module return_stack #(
  parameter int unsigned AW           = 12,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned WRAP_ON_FULL = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [AW-1:0]            data_in_i,
  input  logic                     err_clear_i,
  output logic [AW-1:0]            data_out_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          we;
  logic [PW-1:0] waddr;
  logic          empty, full;

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthC);

  always_comb begin
    top_d       = top_q;
    count_d     = count_q;
    // A fault seen on the same edge is applied after the clear, so the set wins.
    overflow_d  = overflow_q & ~err_clear_i;
    underflow_d = underflow_q & ~err_clear_i;
    we          = 1'b0;
    waddr       = top_q + PW'(1);
    case ({push_i, pop_i})
      2'b10: begin
        if (!full) begin
          we      = 1'b1;
          top_d   = top_q + PW'(1);
          count_d = count_q + CW'(1);
        end else begin
          overflow_d = 1'b1;
          // When full, top+1 (mod DEPTH) is the oldest slot, so advancing overwrites it.
          if (WRAP_ON_FULL != 0) begin
            we    = 1'b1;
            top_d = top_q + PW'(1);
          end
        end
      end
      2'b01: begin
        if (!empty) begin
          top_d   = top_q - PW'(1);
          count_d = count_q - CW'(1);
        end else begin
          underflow_d = 1'b1;
        end
      end
      2'b11: begin
        we = 1'b1;
        if (!empty) begin
          // Tail call: the return address is replaced in place.
          waddr = top_q;
        end else begin
          top_d   = top_q + PW'(1);
          count_d = CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      top_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      top_q       <= top_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset; reads are masked to 0 while empty.
  always_ff @(posedge clk) begin
    if (reset && we) begin
      mem_q[waddr] <= data_in_i;
    end
  end

  assign data_out_o  = empty ? '0 : mem_q[top_q];
  assign count_o     = count_q;
  assign empty_o     = empty;
  assign full_o      = full;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule
